demux1_8_tdm: RTL and testbench

Time-division 1:8 demultiplexer and deserializer: the receive end of a link in which an 8:1 mux steps its select 0..7 and sends one bit per slot. It tracks the slot index, places each received bit in its slot position, and presents the reassembled 8-bit word with a one-cycle valid strobe. It sits downstream of the serial 8:1 select path and restores the parallel `x[7:0]` word at the far end.

---
 rtl/demux1_8_tdm.sv | 118 +++++++++++
 tb/tb_demux1_8_tdm.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/demux1_8_tdm.sv
// demux1_8_tdm: receive end of an 8-slot TDM link; re-assembles serial slot bits into y[7:0].
// Optional early-sync error pulse on frame_err is built only when DEMUX_FRAME_ERR_EN is defined.
module demux1_8_tdm (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       din,
  input  logic       din_valid,
  input  logic       sync,
  output logic [7:0] y,
  output logic       y_valid,
  output logic [2:0] sel,
  output logic       locked,
  output logic       frame_err
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t     state_r;
  state_t     state_s;
  logic [2:0] cnt_r;
  logic [2:0] cnt_s;
  logic [7:0] buf_r;
  logic [7:0] buf_s;
  logic [7:0] y_r;
  logic [7:0] y_s;
  logic       y_valid_r;
  logic       y_valid_s;
  logic       locked_r;

  // Next-state: sync always restarts the frame at slot 0; slot 7 completes the word.
  always_comb begin
    state_s   = state_r;
    cnt_s     = cnt_r;
    buf_s     = buf_r;
    y_s       = y_r;
    y_valid_s = 1'b0;
    if (din_valid) begin
      if (sync) begin
        buf_s[0] = din;
        cnt_s    = 3'd1;
        state_s  = ST_RUN;
      end else begin
        case (state_r)
          ST_RUN: begin
            if (cnt_r == 3'd7) begin
              y_s       = {din, buf_r[6:0]};
              y_valid_s = 1'b1;
              cnt_s     = 3'd0;
            end else begin
              buf_s[cnt_r] = din;
              cnt_s        = cnt_r + 3'd1;
            end
          end
          ST_IDLE: begin
            state_s = ST_IDLE;
          end
          default: begin
            state_s = ST_IDLE;
            cnt_s   = 3'd0;
          end
        endcase
      end
    end else begin
      state_s = state_r;
    end
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r   <= ST_IDLE;
      cnt_r     <= 3'd0;
      buf_r     <= 8'h00;
      y_r       <= 8'h00;
      y_valid_r <= 1'b0;
      locked_r  <= 1'b0;
    end else begin
      state_r   <= state_s;
      cnt_r     <= cnt_s;
      buf_r     <= buf_s;
      y_r       <= y_s;
      y_valid_r <= y_valid_s;
      locked_r  <= (state_s == ST_RUN);
    end
  end

  assign y       = y_r;
  assign y_valid = y_valid_r;
  assign sel     = cnt_r;
  assign locked  = locked_r;

`ifdef DEMUX_FRAME_ERR_EN
  logic early_sync_s;
  logic frame_err_r;

  // A sync landing mid-frame while locked means the transmitter slipped.
  always_comb begin
    early_sync_s = din_valid && sync && (state_r == ST_RUN) && (cnt_r != 3'd0);
  end

  // Error pulse register, one cycle per early sync.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      frame_err_r <= 1'b0;
    end else begin
      frame_err_r <= early_sync_s;
    end
  end

  assign frame_err = frame_err_r;
`else
  assign frame_err = 1'b0;
`endif

endmodule

// File: tb/tb_demux1_8_tdm.sv
// Self-checking bench for demux1_8_tdm: directed vector table followed by randomized
// traffic compared against a queue-based frame model.
module tb_demux1_8_tdm;

`ifdef DEMUX_FRAME_ERR_EN
  localparam logic FE = 1'b1;
`else
  localparam logic FE = 1'b0;
`endif

  logic       clk;
  logic       rst_n;
  logic       din;
  logic       din_valid;
  logic       sync;
  logic [7:0] y;
  logic       y_valid;
  logic [2:0] sel;
  logic       locked;
  logic       frame_err;

  int errors = 0;
  int checks = 0;

  demux1_8_tdm dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .din       (din),
    .din_valid (din_valid),
    .sync      (sync),
    .y         (y),
    .y_valid   (y_valid),
    .sel       (sel),
    .locked    (locked),
    .frame_err (frame_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst_n;
    logic       dv;
    logic       sy;
    logic       d;
    logic [7:0] y;
    logic       yv;
    logic [2:0] sel;
    logic       lk;
    logic       fe;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic r, input logic dv, input logic sy, input logic d,
                              input logic [7:0] ey, input logic eyv, input logic [2:0] esel,
                              input logic elk, input logic efe);
    vec_t v;
    v.rst_n = r; v.dv = dv; v.sy = sy; v.d = d;
    v.y = ey; v.yv = eyv; v.sel = esel; v.lk = elk; v.fe = efe;
    return v;
  endfunction

  // Push n slot bits of word w (slot k carries w[k]); optional gap after slot gap_at.
  task automatic add_bits(input logic [7:0] w, input int n, input logic with_sync,
                          input logic lk, input logic [7:0] y_prev, input int gap_at,
                          input int gap_len, input logic fe_first);
    for (int k = 0; k < n; k++) begin
      logic [2:0] es;
      logic [7:0] ey;
      es = lk ? 3'((k + 1) % 8) : 3'd0;
      ey = (lk && k == 7) ? w : y_prev;
      tbl.push_back(mk(1'b1, 1'b1, (k == 0) ? with_sync : 1'b0, w[k], ey,
                       lk && (k == 7), es, lk, (k == 0) ? fe_first : 1'b0));
      if (k == gap_at) begin
        for (int g = 0; g < gap_len; g++) begin
          tbl.push_back(mk(1'b1, 1'b0, 1'b1, 1'b1, ey, 1'b0, es, lk, 1'b0));
        end
      end
    end
  endtask

  task automatic compare(input string name, input logic [7:0] ey, input logic eyv,
                         input logic [2:0] esel, input logic elk, input logic efe);
    checks++;
    if (y !== ey || y_valid !== eyv || sel !== esel || locked !== elk || frame_err !== efe) begin
      errors++;
      $display("FAIL %s: got y=%h y_valid=%b sel=%0d locked=%b frame_err=%b, want y=%h y_valid=%b sel=%0d locked=%b frame_err=%b",
               name, y, y_valid, sel, locked, frame_err, ey, eyv, esel, elk, efe);
    end
  endtask

  // Reference model: the frame is the queue of bits accepted since the last sync/wrap.
  bit         m_locked;
  bit         m_q[$];
  logic [7:0] m_y;
  bit         m_yv;
  bit         m_fe;

  task automatic model_step(input logic r, input logic dv, input logic sy, input logic d);
    m_yv = 1'b0;
    m_fe = 1'b0;
    if (!r) begin
      m_locked = 1'b0;
      m_q.delete();
      m_y = 8'h00;
    end else if (dv) begin
      if (sy) begin
        m_fe = FE && m_locked && (m_q.size() != 0);
        m_q.delete();
        m_q.push_back(d);
        m_locked = 1'b1;
      end else if (m_locked) begin
        m_q.push_back(d);
        if (m_q.size() == 8) begin
          m_y = 8'h00;
          foreach (m_q[i]) m_y = m_y | (8'(m_q[i]) << i);
          m_yv = 1'b1;
          m_q.delete();
        end
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; din = 1'b0; din_valid = 1'b0; sync = 1'b0;

    // Reset, then idle with noise on sync/din.
    for (int i = 0; i < 2; i++) tbl.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 3'd0, 1'b0, 1'b0));
    for (int i = 0; i < 10; i++) tbl.push_back(mk(1'b1, 1'b0, 1'(i), 1'b1, 8'h00, 1'b0, 3'd0, 1'b0, 1'b0));
    // Locked frame 4D, then one idle cycle.
    add_bits(8'h4D, 8, 1'b1, 1'b1, 8'h00, -1, 0, 1'b0);
    tbl.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 8'h4D, 1'b0, 3'd0, 1'b1, 1'b0));
    // Reset, unsynced drop, back-to-back A5 (sync) then 3C (no sync).
    tbl.push_back(mk(1'b0, 1'b1, 1'b1, 1'b1, 8'h00, 1'b0, 3'd0, 1'b0, 1'b0));
    add_bits(8'h1F, 5, 1'b0, 1'b0, 8'h00, -1, 0, 1'b0);
    add_bits(8'hA5, 8, 1'b1, 1'b1, 8'h00, -1, 0, 1'b0);
    add_bits(8'h3C, 8, 1'b0, 1'b1, 8'hA5, -1, 0, 1'b0);
    // Frame F0 with a 3-cycle gap after slot 4, then reset after slot 3 of the next frame.
    add_bits(8'hF0, 8, 1'b1, 1'b1, 8'h3C, 4, 3, 1'b0);
    add_bits(8'h55, 4, 1'b1, 1'b1, 8'hF0, -1, 0, 1'b0);
    tbl.push_back(mk(1'b0, 1'b1, 1'b0, 1'b1, 8'h00, 1'b0, 3'd0, 1'b0, 1'b0));
    tbl.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 3'd0, 1'b0, 1'b0));
    // Early sync at slot 5 carrying slot 0 of 81.
    add_bits(8'h1F, 5, 1'b1, 1'b1, 8'h00, -1, 0, 1'b0);
    add_bits(8'h81, 8, 1'b1, 1'b1, 8'h00, -1, 0, FE);
    tbl.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 8'h81, 1'b0, 3'd0, 1'b1, 1'b0));

    foreach (tbl[i]) begin
      rst_n = tbl[i].rst_n; din_valid = tbl[i].dv; sync = tbl[i].sy; din = tbl[i].d;
      @(posedge clk);
      #1;
      compare($sformatf("vec%0d", i), tbl[i].y, tbl[i].yv, tbl[i].sel, tbl[i].lk, tbl[i].fe);
    end

    // Randomized traffic from a reset against the model.
    rst_n = 1'b0; din_valid = 1'b0; sync = 1'b0; din = 1'b0;
    model_step(rst_n, din_valid, sync, din);
    @(posedge clk);
    #1;
    compare("rand_reset", m_y, m_yv, 3'(m_q.size()), m_locked, m_fe);
    for (int c = 0; c < 3000; c++) begin
      rst_n     = ($urandom_range(0, 199) != 0);
      din_valid = ($urandom_range(0, 3) != 0);
      sync      = ($urandom_range(0, 11) == 0);
      din       = 1'($urandom);
      model_step(rst_n, din_valid, sync, din);
      @(posedge clk);
      #1;
      compare($sformatf("rand%0d", c), m_y, m_yv, 3'(m_q.size()), m_locked, m_fe);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
